// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single Wishbone-style memory bus between instruction fetch (IF) and load/store (MEM).
// Optional cycle watchdog compiled in with `define BUS_ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,

  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  output logic        if_err_o,
  output logic        stallreq_if_o,

  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ack_o,
  output logic        mem_err_o,
  output logic        stallreq_mem_o,

  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT_IF  = 2'd1,
    GRANT_MEM = 2'd2,
    DRAIN     = 2'd3
  } state_e;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mem_bus_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

  state_e      state_q;
  logic        cyc_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] mem_rdata_q;
  logic        if_ack_q;
  logic        mem_ack_q;

  // A port whose ack is pulsing this cycle is still holding req; it must not be re-granted.
  logic if_eligible;
  logic mem_eligible;
  assign if_eligible  = if_req_i  & ~if_ack_q;
  assign mem_eligible = mem_req_i & ~mem_ack_q;

`ifdef BUS_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt_q;
  logic        wd_expired;
  logic        if_err_q;
  logic        mem_err_q;
  assign wd_expired = (wd_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`endif

  // NOTE: every register below is written with <= so all of them sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'h0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      if_rdata_q  <= 32'h0;
      mem_rdata_q <= 32'h0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      wd_cnt_q    <= 16'h0;
      if_err_q    <= 1'b0;
      mem_err_q   <= 1'b0;
`endif
    end else begin
      // Completion flags are single-cycle pulses.
      if_ack_q  <= 1'b0;
      mem_ack_q <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      if_err_q  <= 1'b0;
      mem_err_q <= 1'b0;
      wd_cnt_q  <= wd_cnt_q + 16'd1;
`endif
      unique case (state_q)
        IDLE: begin
          if (!flush_i && mem_eligible) begin
            state_q <= GRANT_MEM;
            cyc_q   <= 1'b1;
            we_q    <= mem_we_i;
            sel_q   <= mem_sel_i;
            addr_q  <= mem_addr_i;
            wdata_q <= mem_wdata_i;
`ifdef BUS_ARB_TIMEOUT_EN
            wd_cnt_q <= 16'h0;
`endif
          end else if (!flush_i && if_eligible) begin
            state_q <= GRANT_IF;
            cyc_q   <= 1'b1;
            we_q    <= 1'b0;
            sel_q   <= 4'hF;
            addr_q  <= if_addr_i;
            wdata_q <= 32'h0;
`ifdef BUS_ARB_TIMEOUT_EN
            wd_cnt_q <= 16'h0;
`endif
          end
        end

        GRANT_IF, GRANT_MEM: begin
          if (bus_ack_i) begin
            // An ack coinciding with a flush is still delivered.
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            if (state_q == GRANT_IF) begin
              if_rdata_q <= bus_rdata_i;
              if_ack_q   <= 1'b1;
            end else begin
              mem_rdata_q <= bus_rdata_i;
              mem_ack_q   <= 1'b1;
            end
`ifdef BUS_ARB_TIMEOUT_EN
          end else if (wd_expired) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            if (state_q == GRANT_IF) begin
              if_rdata_q <= 32'h0;
              if_ack_q   <= 1'b1;
              if_err_q   <= 1'b1;
            end else begin
              mem_rdata_q <= 32'h0;
              mem_ack_q   <= 1'b1;
              mem_err_q   <= 1'b1;
            end
`endif
          end else if (flush_i) begin
            state_q <= DRAIN;
`ifdef BUS_ARB_TIMEOUT_EN
            wd_cnt_q <= 16'h0;
`endif
          end
        end

        DRAIN: begin
          // The slave must still see its cycle complete; the response is discarded.
`ifdef BUS_ARB_TIMEOUT_EN
          if (bus_ack_i || wd_expired) begin
`else
          if (bus_ack_i) begin
`endif
            state_q <= IDLE;
            cyc_q   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus_cyc_o   = cyc_q;
  assign bus_stb_o   = cyc_q;
  assign bus_we_o    = we_q;
  assign bus_sel_o   = sel_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;

  assign if_rdata_o  = if_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign mem_rdata_o = mem_rdata_q;
  assign mem_ack_o   = mem_ack_q;

`ifdef BUS_ARB_TIMEOUT_EN
  assign if_err_o  = if_err_q;
  assign mem_err_o = mem_err_q;
`else
  assign if_err_o  = 1'b0;
  assign mem_err_o = 1'b0;
`endif

  assign stallreq_if_o  = if_req_i  & ~if_ack_q  & ~flush_i;
  assign stallreq_mem_o = mem_req_i & ~mem_ack_q & ~flush_i;

endmodule
